// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length word, N little-endian data words, optional trailer.
// Optional checksum trailer check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH_WORDS = 2048,
    parameter int AW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK = 3'd6
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
`endif

    logic        byte_in;
    logic        last_byte;
    logic [31:0] full_word;

    // Incoming byte lands on top; after four bytes the first one sits in bits 7:0.
    assign byte_in   = rx_valid && rx_ready;
    assign last_byte = byte_in && (byte_cnt_q == 2'd3);
    assign full_word = {rx_data, shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (byte_in) begin
            shift_d    = full_word[31:8];
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_LEN: begin
                if (last_byte) begin
                    if (full_word > 32'(DEPTH_WORDS)) begin
                        state_d = S_ERR;
                    end else if (full_word == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                        len_d   = full_word[AW:0];
                    end
                end
            end
            S_DATA: begin
                // Address/data only change on entry to WRITE so they stay stable elsewhere.
                if (last_byte) begin
                    state_d = S_WRITE;
                    waddr_d = word_cnt_q[AW-1:0];
                    wdata_d = full_word;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d      = sum_q + wdata_q;
`endif
                if ((word_cnt_q + 1'b1) < len_q) begin
                    state_d = S_DATA;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (last_byte) begin
                    state_d = (full_word == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LEN, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: begin
                rx_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
        we       = (state_q == S_WRITE);
        done     = (state_q == S_DONE);
        err      = (state_q == S_ERR);
        cpu_hold = busy;
        waddr    = waddr_q;
        wdata    = wdata_q;
    end

endmodule
